// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//
// Dynamic next-PC predictor and misprediction controller for the pipelined
// RV32I core. A direct-mapped BTB/BHT table answers a zero-latency lookup for
// the fetch PC. The branch unit's resolved outcome in EX is compared with the
// prediction carried down the pipe. On a mismatch a redirect is raised, and the
// table is trained at the clock edge.
//
// Optional feature macro: BP_STATS_EN
//   When it is defined, the o_stat_branch/o_stat_miss ports and their
//   counters are built. When it is undefined, they do not exist.
//
// Parameters
//   ENTRY_BITS        log2 of the number of table entries (default 4 -> 16)
//
// Ports
//   i_clk             core clock
//   i_rst             asynchronous, active-high reset
//   i_if_pc           current fetch PC
//   o_pred_taken      predict taken for i_if_pc
//   o_pred_target     predicted next PC (i_if_pc+4 when not taken)
//   i_ex_valid        EX holds a real instruction
//   i_ex_stall        EX is frozen this cycle
//   i_ex_pc           PC of the EX instruction
//   i_ex_br_type      0 jal, 1 jalr, 2..7 conditional, >=8 not a branch
//   i_ex_npc_sel      resolved select, nonzero = taken
//   i_ex_target       resolved taken target
//   i_ex_pred_taken   prediction carried from IF
//   i_ex_pred_target  predicted target carried from IF
//   o_redirect        mispredict: flush IF/ID and ID/EX and load the PC
//   o_redirect_pc     corrected PC
//   o_stat_branch     resolved control instructions (BP_STATS_EN only)
//   o_stat_miss       redirect cycles (BP_STATS_EN only)
// -----------------------------------------------------------------------------
module branch_predictor #(
  parameter int ENTRY_BITS = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_if_pc,
  output logic        o_pred_taken,
  output logic [31:0] o_pred_target,
  input  logic        i_ex_valid,
  input  logic        i_ex_stall,
  input  logic [31:0] i_ex_pc,
  input  logic [3:0]  i_ex_br_type,
  input  logic [1:0]  i_ex_npc_sel,
  input  logic [31:0] i_ex_target,
  input  logic        i_ex_pred_taken,
  input  logic [31:0] i_ex_pred_target,
  output logic        o_redirect,
  output logic [31:0] o_redirect_pc
`ifdef BP_STATS_EN
  ,
  output logic [31:0] o_stat_branch,
  output logic [31:0] o_stat_miss
`endif
);

  localparam int NUM_ENTRIES = 1 << ENTRY_BITS;
  localparam int TAG_W       = 32 - ENTRY_BITS - 2;

  // ---------------------------------------------------------------------------
  // 2-bit saturating counter helpers
  // ---------------------------------------------------------------------------
  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    if (c == 2'b11) begin
      ctr_inc = 2'b11;
    end else begin
      ctr_inc = c + 2'b01;
    end
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    if (c == 2'b00) begin
      ctr_dec = 2'b00;
    end else begin
      ctr_dec = c - 2'b01;
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Table storage
  // ---------------------------------------------------------------------------
  logic             r_valid   [NUM_ENTRIES];
  logic [TAG_W-1:0] r_tag     [NUM_ENTRIES];
  logic [31:0]      r_target  [NUM_ENTRIES];
  logic [1:0]       r_ctr     [NUM_ENTRIES];
  logic             r_is_jump [NUM_ENTRIES];

  // ---------------------------------------------------------------------------
  // Fetch-side lookup wires
  // ---------------------------------------------------------------------------
  logic [ENTRY_BITS-1:0] w_if_idx;
  logic [TAG_W-1:0]      w_if_tag;
  logic                  w_if_hit;
  logic [31:0]           w_if_pc_plus4;

  assign w_if_idx      = i_if_pc[ENTRY_BITS+1:2];
  assign w_if_tag      = i_if_pc[31:ENTRY_BITS+2];
  assign w_if_pc_plus4 = i_if_pc + 32'd4;

  // Combinational lookup. The table is read before any same-cycle write, so a
  // same-index EX update is not seen until the following cycle.
  always_comb begin
    w_if_hit      = 1'b0;
    o_pred_taken  = 1'b0;
    o_pred_target = w_if_pc_plus4;
    if (r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag)) begin
      w_if_hit = 1'b1;
    end else begin
      w_if_hit = 1'b0;
    end
    o_pred_taken = w_if_hit && (r_is_jump[w_if_idx] || r_ctr[w_if_idx][1]);
    if (o_pred_taken) begin
      o_pred_target = r_target[w_if_idx];
    end else begin
      o_pred_target = w_if_pc_plus4;
    end
  end

  // ---------------------------------------------------------------------------
  // EX-side resolution wires
  // ---------------------------------------------------------------------------
  logic [ENTRY_BITS-1:0] w_ex_idx;
  logic [TAG_W-1:0]      w_ex_tag;
  logic [31:0]           w_ex_pc_plus4;
  logic                  w_ex_fire;
  logic                  w_ex_is_ctrl;
  logic                  w_ex_is_cond;
  logic                  w_ex_is_jump;
  logic                  w_act_taken;
  logic                  w_miss;
  logic                  w_ex_hit;

  assign w_ex_idx      = i_ex_pc[ENTRY_BITS+1:2];
  assign w_ex_tag      = i_ex_pc[31:ENTRY_BITS+2];
  assign w_ex_pc_plus4 = i_ex_pc + 32'd4;
  assign w_ex_fire     = i_ex_valid && !i_ex_stall;
  assign w_ex_is_ctrl  = (i_ex_br_type <= 4'd7);
  assign w_ex_is_jump  = (i_ex_br_type <= 4'd1);
  assign w_ex_is_cond  = (i_ex_br_type >= 4'd2) && (i_ex_br_type <= 4'd7);
  assign w_ex_hit      = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);

  // Misprediction detection and corrected PC. The corrected PC is always
  // presented; only the redirect strobe is gated by valid/stall.
  always_comb begin
    w_act_taken   = w_ex_is_ctrl && (i_ex_npc_sel != 2'b00);
    w_miss        = 1'b0;
    o_redirect    = 1'b0;
    o_redirect_pc = w_ex_pc_plus4;
    if (w_act_taken != i_ex_pred_taken) begin
      w_miss = 1'b1;
    end else if (w_act_taken && (i_ex_target != i_ex_pred_target)) begin
      w_miss = 1'b1;
    end else begin
      w_miss = 1'b0;
    end
    o_redirect = w_ex_fire && w_miss;
    if (w_act_taken) begin
      o_redirect_pc = i_ex_target;
    end else begin
      o_redirect_pc = w_ex_pc_plus4;
    end
  end

  // ---------------------------------------------------------------------------
  // Update decode: at most one entry write per cycle
  // ---------------------------------------------------------------------------
  logic             w_we;
  logic             w_nxt_valid;
  logic [TAG_W-1:0] w_nxt_tag;
  logic [31:0]      w_nxt_target;
  logic [1:0]       w_nxt_ctr;
  logic             w_nxt_is_jump;

  // Build the next contents of the EX-indexed entry from the resolved outcome.
  always_comb begin
    w_we          = 1'b0;
    w_nxt_valid   = r_valid[w_ex_idx];
    w_nxt_tag     = r_tag[w_ex_idx];
    w_nxt_target  = r_target[w_ex_idx];
    w_nxt_ctr     = r_ctr[w_ex_idx];
    w_nxt_is_jump = r_is_jump[w_ex_idx];
    if (!w_ex_fire) begin
      w_we = 1'b0;
    end else if (w_act_taken && w_ex_hit) begin
      // Taken and resident: strengthen and refresh the target.
      w_we          = 1'b1;
      w_nxt_target  = i_ex_target;
      w_nxt_ctr     = ctr_inc(r_ctr[w_ex_idx]);
      w_nxt_is_jump = w_ex_is_jump;
    end else if (w_act_taken) begin
      // Taken and absent: evict whatever lives here, start weakly taken.
      w_we          = 1'b1;
      w_nxt_valid   = 1'b1;
      w_nxt_tag     = w_ex_tag;
      w_nxt_target  = i_ex_target;
      w_nxt_ctr     = 2'b10;
      w_nxt_is_jump = w_ex_is_jump;
    end else if (w_ex_is_cond && w_ex_hit) begin
      // Conditional not taken and resident: weaken, keep the entry valid.
      w_we      = 1'b1;
      w_nxt_ctr = ctr_dec(r_ctr[w_ex_idx]);
    end else if (!w_ex_is_ctrl && w_ex_hit) begin
      // A non-branch matched the tag: the entry is a stale alias, drop it.
      w_we        = 1'b1;
      w_nxt_valid = 1'b0;
    end else begin
      w_we = 1'b0;
    end
  end

  // Table write port with asynchronous clear of every entry.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_valid[i]   <= 1'b0;
        r_tag[i]     <= '0;
        r_target[i]  <= 32'd0;
        r_ctr[i]     <= 2'b01;
        r_is_jump[i] <= 1'b0;
      end
    end else if (w_we) begin
      r_valid[w_ex_idx]   <= w_nxt_valid;
      r_tag[w_ex_idx]     <= w_nxt_tag;
      r_target[w_ex_idx]  <= w_nxt_target;
      r_ctr[w_ex_idx]     <= w_nxt_ctr;
      r_is_jump[w_ex_idx] <= w_nxt_is_jump;
    end
  end

`ifdef BP_STATS_EN
  // ---------------------------------------------------------------------------
  // Statistics counters (wrap at 2^32)
  // ---------------------------------------------------------------------------
  logic [31:0] r_stat_branch;
  logic [31:0] r_stat_miss;

  // Count resolved control instructions and redirect cycles.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stat_branch <= 32'd0;
      r_stat_miss   <= 32'd0;
    end else begin
      if (w_ex_fire && w_ex_is_ctrl) begin
        r_stat_branch <= r_stat_branch + 32'd1;
      end
      if (o_redirect) begin
        r_stat_miss <= r_stat_miss + 32'd1;
      end
    end
  end

  assign o_stat_branch = r_stat_branch;
  assign o_stat_miss   = r_stat_miss;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic        ex_stall;
  logic [31:0] ex_pc;
  logic [3:0]  ex_br_type;
  logic [1:0]  ex_npc_sel;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        redirect;
  logic [31:0] redirect_pc;
`ifdef BP_STATS_EN
  logic [31:0] stat_branch;
  logic [31:0] stat_miss;
`endif

  branch_predictor #(.ENTRY_BITS(4)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_if_pc          (if_pc),
    .o_pred_taken     (pred_taken),
    .o_pred_target    (pred_target),
    .i_ex_valid       (ex_valid),
    .i_ex_stall       (ex_stall),
    .i_ex_pc          (ex_pc),
    .i_ex_br_type     (ex_br_type),
    .i_ex_npc_sel     (ex_npc_sel),
    .i_ex_target      (ex_target),
    .i_ex_pred_taken  (ex_pred_taken),
    .i_ex_pred_target (ex_pred_target),
    .o_redirect       (redirect),
    .o_redirect_pc    (redirect_pc)
`ifdef BP_STATS_EN
    ,
    .o_stat_branch    (stat_branch),
    .o_stat_miss      (stat_miss)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: 16 entries, each with an integer confidence 0..3.
  typedef struct {
    bit          valid;
    longint      tag;
    logic [31:0] target;
    int          conf;
    bit          jump;
  } ent_t;
  ent_t   m_tab [16];
  longint m_branch;
  longint m_miss;

  function automatic int m_idx(input logic [31:0] pc);
    return int'((longint'(pc) / 4) % 16);
  endfunction

  function automatic longint m_tag(input logic [31:0] pc);
    return longint'(pc) / 64;
  endfunction

  function automatic logic [31:0] plus4(input logic [31:0] pc);
    return 32'((longint'(pc) + 4) % 64'h1_0000_0000);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_tab[m_idx(pc)].valid && (m_tab[m_idx(pc)].tag == m_tag(pc));
  endfunction

  task automatic m_lookup(input logic [31:0] pc, output bit tk, output logic [31:0] tg);
    tk = m_hit(pc) && (m_tab[m_idx(pc)].jump || m_tab[m_idx(pc)].conf >= 2);
    tg = tk ? m_tab[m_idx(pc)].target : plus4(pc);
  endtask

  function automatic bit m_act();
    return (ex_br_type <= 7) && (ex_npc_sel != 0);
  endfunction

  function automatic bit m_redirect();
    bit act = m_act();
    bit miss = (act != ex_pred_taken) || (act && ex_target != ex_pred_target);
    return ex_valid && !ex_stall && miss;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      m_tab[i].valid = 0; m_tab[i].tag = 0; m_tab[i].target = 0;
      m_tab[i].conf = 1; m_tab[i].jump = 0;
    end
    m_branch = 0;
    m_miss   = 0;
  endtask

  // Apply the outcome resolved this cycle to the model (called after the edge).
  task automatic m_update(input bit red);
    int i;
    bit hit;
    if (!(ex_valid && !ex_stall)) return;
    i = m_idx(ex_pc);
    hit = m_hit(ex_pc);
    if (ex_br_type <= 7) m_branch = (m_branch + 1) % 64'h1_0000_0000;
    if (red) m_miss = (m_miss + 1) % 64'h1_0000_0000;
    if (m_act()) begin
      if (!hit) begin
        m_tab[i].valid = 1; m_tab[i].tag = m_tag(ex_pc); m_tab[i].conf = 2;
      end else begin
        m_tab[i].conf = (m_tab[i].conf >= 3) ? 3 : m_tab[i].conf + 1;
      end
      m_tab[i].target = ex_target;
      m_tab[i].jump   = (ex_br_type <= 1);
    end else if (ex_br_type >= 2 && ex_br_type <= 7) begin
      if (hit) m_tab[i].conf = (m_tab[i].conf <= 0) ? 0 : m_tab[i].conf - 1;
    end else if (ex_br_type >= 8) begin
      if (hit) m_tab[i].valid = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model for the current inputs.
  task automatic check_model();
    bit          tk;
    logic [31:0] tg;
    m_lookup(if_pc, tk, tg);
    chk("m_pred_taken", {31'd0, pred_taken}, {31'd0, tk});
    chk("m_pred_target", pred_target, tg);
    chk("m_redirect", {31'd0, redirect}, {31'd0, m_redirect()});
    chk("m_redirect_pc", redirect_pc, m_act() ? ex_target : plus4(ex_pc));
`ifdef BP_STATS_EN
    chk("m_stat_branch", stat_branch, 32'(m_branch));
    chk("m_stat_miss", stat_miss, 32'(m_miss));
`endif
  endtask

  // One cycle: model check before the edge, model update after it.
  task automatic tick();
    bit red;
    @(negedge clk);
    check_model();
    red = m_redirect();
    @(posedge clk);
    if (!rst) m_update(red);
    #1;
  endtask

  task automatic set_ex(input bit v, input bit s, input logic [31:0] pc, input logic [3:0] ty,
                        input logic [1:0] ns, input logic [31:0] tg, input bit pt,
                        input logic [31:0] ptg);
    ex_valid = v; ex_stall = s; ex_pc = pc; ex_br_type = ty; ex_npc_sel = ns;
    ex_target = tg; ex_pred_taken = pt; ex_pred_target = ptg;
  endtask

  task automatic idle();
    set_ex(1'b0, 1'b0, 32'h2000, 4'd15, 2'd0, 32'd0, 1'b0, 32'd0);
  endtask

  // Resolve an instruction whose IF prediction came from the model.
  task automatic resolve(input logic [31:0] pc, input logic [3:0] ty, input logic [1:0] ns,
                         input logic [31:0] tg);
    bit          tk;
    logic [31:0] ptg;
    m_lookup(pc, tk, ptg);
    set_ex(1'b1, 1'b0, pc, ty, ns, tg, tk, ptg);
    tick();
  endtask

  initial begin
    bit          rtk;
    logic [31:0] rtg;
    logic [31:0] rpc;

    rst = 1'b1;
    if_pc = 32'h100;
    idle();
    m_reset();
    #12;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Post-reset lookup and first allocation, including same-index collision.
    #2;
    chk("reset_pred_taken", {31'd0, pred_taken}, 32'd0);
    chk("reset_pred_target", pred_target, 32'h104);
    chk("reset_redirect", {31'd0, redirect}, 32'd0);
    chk("reset_redirect_pc", redirect_pc, 32'h2004);
    tick();
    set_ex(1'b1, 1'b0, 32'h100, 4'd2, 2'd1, 32'h80, 1'b0, 32'h104);
    #2;
    chk("beq_redirect", {31'd0, redirect}, 32'd1);
    chk("beq_redirect_pc", redirect_pc, 32'h80);
    chk("collision_pre_update", {31'd0, pred_taken}, 32'd0);
    tick();
    idle();
    #2;
    chk("trained_taken", {31'd0, pred_taken}, 32'd1);
    chk("trained_target", pred_target, 32'h80);
    tick();

    // Counter saturation on bne at 0x200.
    if_pc = 32'h200;
    for (int k = 0; k < 3; k++) resolve(32'h200, 4'd3, 2'd1, 32'h280);
    resolve(32'h200, 4'd3, 2'd0, 32'h280);
    idle();
    #2;
    chk("sat_still_taken", {31'd0, pred_taken}, 32'd1);
    tick();
    resolve(32'h200, 4'd3, 2'd0, 32'h280);
    idle();
    #2;
    chk("sat_now_not_taken", {31'd0, pred_taken}, 32'd0);
    tick();
    set_ex(1'b1, 1'b0, 32'h200, 4'd3, 2'd0, 32'h280, 1'b0, 32'h204);
    #2;
    chk("sat_no_redirect", {31'd0, redirect}, 32'd0);
    tick();

    // jalr target change.
    if_pc = 32'h300;
    resolve(32'h300, 4'd1, 2'd2, 32'h400);
    set_ex(1'b1, 1'b0, 32'h300, 4'd1, 2'd2, 32'h500, 1'b1, 32'h400);
    #2;
    chk("jalr_redirect", {31'd0, redirect}, 32'd1);
    chk("jalr_redirect_pc", redirect_pc, 32'h500);
    tick();
    idle();
    #2;
    chk("jalr_lookup_taken", {31'd0, pred_taken}, 32'd1);
    chk("jalr_lookup_target", pred_target, 32'h500);
    tick();

    // Stale alias invalidation.
    if_pc = 32'h40;
    resolve(32'h40, 4'd2, 2'd1, 32'h10);
    set_ex(1'b1, 1'b0, 32'h40, 4'd8, 2'd0, 32'h0, 1'b1, 32'h10);
    #2;
    chk("alias_redirect", {31'd0, redirect}, 32'd1);
    chk("alias_redirect_pc", redirect_pc, 32'h44);
    tick();
    idle();
    #2;
    chk("alias_lookup_miss", {31'd0, pred_taken}, 32'd0);
    chk("alias_lookup_target", pred_target, 32'h44);
    tick();

    // Stall hold then release.
    if_pc = 32'h600;
    for (int k = 0; k < 2; k++) begin
      set_ex(1'b1, 1'b1, 32'h600, 4'd2, 2'd1, 32'h700, 1'b0, 32'h604);
      #2;
      chk("stall_no_redirect", {31'd0, redirect}, 32'd0);
      tick();
    end
    set_ex(1'b1, 1'b0, 32'h600, 4'd2, 2'd1, 32'h700, 1'b0, 32'h604);
    #2;
    chk("stall_no_update", {31'd0, pred_taken}, 32'd0);
    chk("release_redirect", {31'd0, redirect}, 32'd1);
    tick();

    // PC wrap at the top of the address space.
    if_pc = 32'hFFFF_FFFC;
    set_ex(1'b1, 1'b0, 32'hFFFF_FFFC, 4'd9, 2'd0, 32'h0, 1'b0, 32'h0);
    #2;
    chk("wrap_redirect_pc", redirect_pc, 32'h0);
    chk("wrap_pred_target", pred_target, 32'h0);
    tick();

    // Randomized traffic over a small aliasing PC pool.
    for (int k = 0; k < 400; k++) begin
      rpc = 32'(($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2));
      m_lookup(rpc, rtk, rtg);
      ex_valid       = ($urandom_range(0, 9) != 0);
      ex_stall       = ($urandom_range(0, 7) == 0);
      ex_pc          = rpc;
      ex_br_type     = 4'($urandom_range(0, 11));
      ex_npc_sel     = 2'($urandom_range(0, 3));
      ex_target      = 32'($urandom_range(0, 7) << 4);
      if ($urandom_range(0, 9) < 7) begin
        ex_pred_taken  = rtk;
        ex_pred_target = rtg;
      end else begin
        ex_pred_taken  = 1'($urandom_range(0, 1));
        ex_pred_target = 32'($urandom_range(0, 7) << 4);
      end
      if_pc = ($urandom_range(0, 1) == 1) ? rpc
            : 32'(($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2));
      tick();
    end

    // Asynchronous reset between edges clears the prediction immediately.
    if_pc = 32'h100;
    resolve(32'h100, 4'd0, 2'd2, 32'h900);
    idle();
    #2;
    chk("pre_reset_taken", {31'd0, pred_taken}, 32'd1);
    rst = 1'b1;
    #1;
    chk("async_reset_taken", {31'd0, pred_taken}, 32'd0);
    chk("async_reset_target", pred_target, 32'h104);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

`ifdef BP_STATS_EN
    // Five branches, two of them mispredicted.
    for (int k = 0; k < 3; k++) begin
      set_ex(1'b1, 1'b0, 32'h500 + 32'(k * 4), 4'd4, 2'd0, 32'h0, 1'b0, 32'h0);
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      set_ex(1'b1, 1'b0, 32'h600 + 32'(k * 4), 4'd5, 2'd1, 32'h20, 1'b0, 32'h0);
      tick();
    end
    idle();
    #2;
    chk("stat_branch", stat_branch, 32'd5);
    chk("stat_miss", stat_miss, 32'd2);
    rst = 1'b1;
    #1;
    chk("stat_branch_reset", stat_branch, 32'd0);
    chk("stat_miss_reset", stat_miss, 32'd0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
`endif

    idle();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic next-PC predictor and misprediction controller for the pipelined RV32I core. Sits beside the PC register: it answers a zero-latency BTB/BHT lookup for the fetch PC, and it compares the branch unit's resolved `npc_sel`/target in EX against the prediction carried down the pipe. On a mismatch it raises a redirect and flush, and it trains its tables at the clock edge.

## Interface
- `ENTRY_BITS`, 4: log2 of the number of table entries (16 by default).
- `clk`  in  1: core clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `if_pc`  in  32: current fetch PC.
- `pred_taken`  out  1: predict taken for `if_pc`.
- `pred_target`  out  32: predicted target. Equals `if_pc+4` when `pred_taken`=0.
- `ex_valid`  in  1: EX holds a real instruction, not a bubble.
- `ex_stall`  in  1: EX is frozen this cycle.
- `ex_pc`  in  32: PC of the EX instruction.
- `ex_br_type`  in  4: branch type, same encoding as the branch unit.
  - 0 jal, 1 jalr, 2 beq, 3 bne, 4 blt, 5 bge, 6 bltu, 7 bgeu.
  - 8 or above: not a branch.
- `ex_npc_sel`  in  2: resolved select from the branch unit. Nonzero means taken.
- `ex_target`  in  32: resolved taken target (already `&~1` for jalr).
- `ex_pred_taken`  in  1: prediction for this instruction, piped from IF.
- `ex_pred_target`  in  32: predicted target for this instruction, piped from IF.
- `redirect`  out  1: mispredict. Flushes IF/ID and ID/EX and loads the PC.
- `redirect_pc`  out  32: corrected PC.
- `stat_branch`, `stat_miss`  out  32 each: present only with `BP_STATS_EN`.

## Operation
- **Entry contents:** `valid`, `tag` = pc[31:ENTRY_BITS+2], `target`[31:0], `ctr`[1:0], `is_jump`.
- **Index:** pc[ENTRY_BITS+1:2].
- **Lookup (combinational):**
  - `hit` = `valid` && (`tag` matches).
  - `pred_taken` = `hit` && (`is_jump` || `ctr`[1]).
  - `pred_target` = `pred_taken` ? `target` : `if_pc+4`.
- **Resolution (when `ex_valid` && !`ex_stall`):**
  - `act_taken` = (`ex_br_type`<=7) && (`ex_npc_sel`!=0).
  - `miss` = (`act_taken` != `ex_pred_taken`) || (`act_taken` && `ex_target` != `ex_pred_target`).
  - `redirect` = `miss`.
  - `redirect_pc` = `act_taken` ? `ex_target` : `ex_pc+4`.
- **Update:** at the clock edge, only when `ex_valid` && !`ex_stall`, on the entry indexed by `ex_pc`.
  - Taken, entry hit: `target` ← `ex_target`; `ctr` saturating increment (max 3); `is_jump` ← (`ex_br_type`<=1).
  - Taken, entry miss: allocate/overwrite the entry. `valid`=1, `tag`, `target`, `ctr`=2'b10, `is_jump` as above.
  - Conditional not taken, entry hit: `ctr` saturating decrement (min 0). The entry stays valid.
  - Conditional not taken, entry miss: no change.
  - Non-branch (`ex_br_type`>=8) that hits: invalidate the entry (stale alias). Otherwise no change.
- **Gating:** `ex_stall`=1 or `ex_valid`=0 forces `redirect`=0 and blocks all updates. A stalled mispredict therefore redirects in the cycle its stall releases.
- **Counter arithmetic:** 2-bit saturating, no wrap. `pc+4` is modulo 2^32, so 0xFFFFFFFC+4 = 0.

## Timing
- **Reset values:**
  - All `valid`=0 and all `ctr`=2'b01.
  - `pred_taken`=0, `pred_target`=`if_pc+4`, `redirect`=0, `redirect_pc`=`ex_pc+4`.
  - Stat counters = 0.
- **Reset mid-operation:** the asynchronous clear takes effect immediately, with no partial update.
- **Latency:**
  - Lookup: 0 cycles.
  - Redirect: 0 cycles, same cycle as EX resolution.
  - Table update: visible to lookups from the cycle after the edge.
- **Same-index collision:** if IF and EX map to the same index in one cycle, IF sees the pre-update contents. Write-first bypass is not allowed.
- **Single write port:** one update per cycle at most. A new allocation evicts the resident entry unconditionally.
- **Combinational paths:** `redirect` depends combinationally on the EX inputs. The consumer registers the PC on the same edge.

## Configuration
- `BP_STATS_EN` defined:
  - `stat_branch` counts resolved control instructions (`ex_br_type`<=7, `ex_valid`, !`ex_stall`).
  - `stat_miss` counts cycles with `redirect`=1.
  - Both counters are 32-bit and wrap at 2^32.
- `BP_STATS_EN` not defined: the ports and counters do not exist. Behaviour is otherwise identical.

## Test plan
- **Post-reset lookup:** after reset, `if_pc`=0x100 → `pred_taken`=0, `pred_target`=0x104. Resolve beq at 0x100 taken to 0x80 → `redirect`=1, `redirect_pc`=0x80. Next cycle, `if_pc`=0x100 → `pred_taken`=1, `pred_target`=0x80.
- **Counter saturation:** resolve bne at 0x200 taken 3 times, then not taken once → still predicted taken (`ctr` 3→2). One more not-taken → predicted not taken. A further not-taken with `ex_pred_taken`=0 → `redirect`=0.
- **jalr target change:** jalr at 0x300 resolves to 0x400, then to 0x500 with `ex_pred_target`=0x400 → `redirect`=1, `redirect_pc`=0x500. Lookup then returns 0x500, and `is_jump` keeps it taken.
- **Stale alias:** allocate 0x40 taken. Resolve `ex_br_type`=8 at 0x40 with `ex_pred_taken`=1 → `redirect`=1, `redirect_pc`=0x44. Entry invalidated, so the next lookup misses.
- **Stall hold:** mispredict with `ex_stall`=1 for 2 cycles → `redirect`=0 and no update during the stall. `redirect`=1 in the release cycle.
- **Async reset and stats:** assert `rst` between edges after training → `pred_taken`=0 immediately. With `BP_STATS_EN`, 5 branches with 2 misses → `stat_branch`=5, `stat_miss`=2, and both return to 0 on reset.
